// File: rtl/harmonogram_faz_pkg.sv
// Shared types and constants for the valve-timing sequencer.
// Angle width, cycle length, FSM encodings and phase-table bundle.
package harmonogram_faz_pkg;

  localparam int ANGLE_W       = 10;
  localparam int DEG_PER_CYCLE = 720;

  localparam logic [ANGLE_W-1:0] KAT_MAX =
    ANGLE_W'(DEG_PER_CYCLE - 1);

  typedef enum logic {
    STOP,
    RUN
  } eng_state_t;

  typedef enum logic {
    CFG_EMPTY,
    CFG_PENDING
  } cfg_state_t;

  typedef struct packed {
    logic [ANGLE_W-1:0] on;
    logic [ANGLE_W-1:0] off;
  } okno_t;

  typedef struct packed {
    okno_t ssacy;
    okno_t wydechowy;
    okno_t wtrysk;
    okno_t iskra;
  } tabela_t;

  function automatic logic kat_ok(
    input logic [ANGLE_W-1:0] v
  );
    return v < ANGLE_W'(DEG_PER_CYCLE);
  endfunction

  function automatic logic tabela_ok(
    input tabela_t t
  );
    return kat_ok(t.ssacy.on)
      && kat_ok(t.ssacy.off)
      && kat_ok(t.wydechowy.on)
      && kat_ok(t.wydechowy.off)
      && kat_ok(t.wtrysk.on)
      && kat_ok(t.wtrysk.off)
      && kat_ok(t.iskra.on)
      && kat_ok(t.iskra.off);
  endfunction

endpackage

// File: rtl/harmonogram_faz_okno_katowe.sv
// Angle window decode: active while kat lies in [on, off),
// wrapping through 0 when on > off. Ports: i_kat, i_on, i_off, o_active.
module okno_katowe
  import harmonogram_faz_pkg::*;
(
  input  logic [ANGLE_W-1:0] i_kat,
  input  logic [ANGLE_W-1:0] i_on,
  input  logic [ANGLE_W-1:0] i_off,
  output logic               o_active
);

  always_comb begin
    o_active = 1'b0;
    unique case (1'b1)
      (i_on == i_off):
        o_active = 1'b0;
      (i_on < i_off):
        o_active = (i_kat >= i_on)
          && (i_kat < i_off);
      default:
        o_active = (i_kat >= i_on)
          || (i_kat < i_off);
    endcase
  end

endmodule

// File: rtl/harmonogram_faz.sv
// Valve-timing sequencer: crank angle generator, engine FSM, phase-table
// handshake with shadow/active tables, and four registered actuator drives.
// Ports: clk, rst_n, rpm, tdc_sync, cfg_valid/cfg_ready, 8 cfg_on/off_*,
// kat, cycle_start, zawor_ssacy, zawor_wydechowy, wtrysk, iskra, cfg_err.
module harmonogram_faz
  import harmonogram_faz_pkg::*;
#(
  parameter int DEG_THRESH = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         rpm,
  input  logic               tdc_sync,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ANGLE_W-1:0] cfg_on_ssacy,
  input  logic [ANGLE_W-1:0] cfg_off_ssacy,
  input  logic [ANGLE_W-1:0] cfg_on_wydechowy,
  input  logic [ANGLE_W-1:0] cfg_off_wydechowy,
  input  logic [ANGLE_W-1:0] cfg_on_wtrysk,
  input  logic [ANGLE_W-1:0] cfg_off_wtrysk,
  input  logic [ANGLE_W-1:0] cfg_on_iskra,
  input  logic [ANGLE_W-1:0] cfg_off_iskra,
  output logic [ANGLE_W-1:0] kat,
  output logic               cycle_start,
  output logic               zawor_ssacy,
  output logic               zawor_wydechowy,
  output logic               wtrysk,
  output logic               iskra,
  output logic               cfg_err
);

  localparam int ACC_W = $clog2(DEG_THRESH + 128);
  localparam logic [ACC_W-1:0] THRESH =
    ACC_W'(DEG_THRESH);

  eng_state_t         r_eng;
  cfg_state_t         r_cfg;
  logic [ACC_W-1:0]   r_acc;
  logic [ANGLE_W-1:0] r_kat;
  logic               r_cs;
  logic               r_ready;
  logic               r_err;
  tabela_t            r_shadow;
  tabela_t            r_active;
  logic [3:0]         r_drive;

  logic [ACC_W-1:0]   w_sum;
  logic               w_tick;
  logic               w_zero;
  logic               w_apply;
  logic               w_xfer;
  tabela_t            w_cfg;
  logic [3:0]         w_win;

  assign w_sum  = r_acc + ACC_W'(rpm);
  assign w_tick = (r_eng == RUN)
    && (w_sum >= THRESH);

  // kat becomes 0 on this edge: table swap point
  assign w_zero = tdc_sync
    || (w_tick && (r_kat == KAT_MAX));

  assign w_xfer  = cfg_valid && r_ready;
  assign w_apply = (r_cfg == CFG_PENDING)
    && ((r_eng == STOP) || w_zero);

  assign w_cfg.ssacy.on      = cfg_on_ssacy;
  assign w_cfg.ssacy.off     = cfg_off_ssacy;
  assign w_cfg.wydechowy.on  = cfg_on_wydechowy;
  assign w_cfg.wydechowy.off = cfg_off_wydechowy;
  assign w_cfg.wtrysk.on     = cfg_on_wtrysk;
  assign w_cfg.wtrysk.off    = cfg_off_wtrysk;
  assign w_cfg.iskra.on      = cfg_on_iskra;
  assign w_cfg.iskra.off     = cfg_off_iskra;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eng <= STOP;
    end else begin
      unique case (r_eng)
        STOP:
          if (rpm != 7'd0) r_eng <= RUN;
        RUN:
          if (rpm == 7'd0) r_eng <= STOP;
        default:
          r_eng <= STOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_kat <= '0;
      r_cs  <= 1'b0;
    end else if (tdc_sync) begin
      r_acc <= '0;
      r_kat <= '0;
      r_cs  <= 1'b1;
    end else if (r_eng == RUN) begin
      if (w_tick) begin
        r_acc <= w_sum - THRESH;
        r_kat <= (r_kat == KAT_MAX)
          ? '0 : r_kat + 1'b1;
        r_cs  <= (r_kat == KAT_MAX);
      end else begin
        r_acc <= w_sum;
        r_cs  <= 1'b0;
      end
    end else begin
      r_cs <= 1'b0;
    end
  end

  // ready rises one clk after apply, since
  // the EMPTY state re-arms it on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg    <= CFG_EMPTY;
      r_ready  <= 1'b1;
      r_err    <= 1'b0;
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      unique case (r_cfg)
        CFG_EMPTY: begin
          if (w_xfer) begin
            if (!tabela_ok(w_cfg)) begin
              r_err <= 1'b1;
            end else begin
              r_shadow <= w_cfg;
              r_cfg    <= CFG_PENDING;
              r_ready  <= 1'b0;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        CFG_PENDING: begin
          if (w_apply) begin
            r_active <= r_shadow;
            r_cfg    <= CFG_EMPTY;
          end
        end
        default:
          r_cfg <= CFG_EMPTY;
      endcase
    end
  end

  okno_katowe u_ssacy (
    .i_kat    (r_kat),
    .i_on     (r_active.ssacy.on),
    .i_off    (r_active.ssacy.off),
    .o_active (w_win[0])
  );

  okno_katowe u_wydechowy (
    .i_kat    (r_kat),
    .i_on     (r_active.wydechowy.on),
    .i_off    (r_active.wydechowy.off),
    .o_active (w_win[1])
  );

  okno_katowe u_wtrysk (
    .i_kat    (r_kat),
    .i_on     (r_active.wtrysk.on),
    .i_off    (r_active.wtrysk.off),
    .o_active (w_win[2])
  );

  okno_katowe u_iskra (
    .i_kat    (r_kat),
    .i_on     (r_active.iskra.on),
    .i_off    (r_active.iskra.off),
    .o_active (w_win[3])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drive <= '0;
    end else begin
      r_drive <= (r_eng == RUN) ? w_win : 4'd0;
    end
  end

  assign kat             = r_kat;
  assign cycle_start     = r_cs;
  assign cfg_ready       = r_ready;
  assign cfg_err         = r_err;
  assign zawor_ssacy     = r_drive[0];
  assign zawor_wydechowy = r_drive[1];
  assign wtrysk          = r_drive[2];
  assign iskra           = r_drive[3];

endmodule

// File: tb/tb_harmonogram_faz.sv
// Directed bench for harmonogram_faz.
// Hand-computed expectations at DEG_THRESH=1000, rpm=50 (20 clk/deg).
module tb_harmonogram_faz;

  logic       clk;
  logic       rst_n;
  logic [6:0] rpm;
  logic       tdc_sync;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [9:0] on_s, off_s, on_w, off_w;
  logic [9:0] on_j, off_j, on_k, off_k;
  logic [9:0] kat;
  logic       cycle_start;
  logic       zs, zw, wt, is;
  logic       cfg_err;

  int n_run  = 0;
  int n_fail = 0;
  int n;
  int frozen;

  harmonogram_faz #(.DEG_THRESH(1000)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rpm               (rpm),
    .tdc_sync          (tdc_sync),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_on_ssacy      (on_s),
    .cfg_off_ssacy     (off_s),
    .cfg_on_wydechowy  (on_w),
    .cfg_off_wydechowy (off_w),
    .cfg_on_wtrysk     (on_j),
    .cfg_off_wtrysk    (off_j),
    .cfg_on_iskra      (on_k),
    .cfg_off_iskra     (off_k),
    .kat               (kat),
    .cycle_start       (cycle_start),
    .zawor_ssacy       (zs),
    .zawor_wydechowy   (zw),
    .wtrysk            (wt),
    .iskra             (is),
    .cfg_err           (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d",
        tag, got, exp);
    end
  endtask

  task automatic wait_kat(
    input string tag,
    input int    target,
    input int    budget
  );
    int i;
    i = 0;
    while (int'(kat) != target && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, int'(kat), target);
  endtask

  task automatic send(
    input logic [9:0] a, b, c, d,
    input logic [9:0] e, f, g, h
  );
    on_s = a; off_s = b;
    on_w = c; off_w = d;
    on_j = e; off_j = f;
    on_k = g; off_k = h;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rpm = 7'd0;
    tdc_sync = 1'b0;
    cfg_valid = 1'b0;
    on_s = '0; off_s = '0; on_w = '0; off_w = '0;
    on_j = '0; off_j = '0; on_k = '0; off_k = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (200) @(negedge clk);
    chk("t1_kat", kat, 0);
    chk("t1_drv", {zs, zw, wt, is}, 0);
    chk("t1_rdy", cfg_ready, 1);
    chk("t1_err", cfg_err, 0);
    chk("t1_cs", cycle_start, 0);

    // 3: table loaded while stopped
    send(700, 20, 0, 0, 0, 0, 0, 0);
    chk("t3_rdy_lo", cfg_ready, 0);
    repeat (2) @(negedge clk);
    chk("t3_rdy_hi", cfg_ready, 1);
    chk("t3_stop_drv", zs, 0);

    // 2/3: run, degree period, window
    rpm = 7'd50;
    wait_kat("t3_w5", 5, 200);
    repeat (2) @(negedge clk);
    chk("t3_s_k5", zs, 1);
    wait_kat("t2_w6", 6, 40);
    n = 0;
    while (kat != 10'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t2_period", n, 20);
    wait_kat("t3_w19", 19, 400);
    repeat (2) @(negedge clk);
    chk("t3_s_k19", zs, 1);
    wait_kat("t3_w20", 20, 40);
    repeat (2) @(negedge clk);
    chk("t3_s_k20", zs, 0);

    // 4: new table mid-cycle
    wait_kat("t4_w300", 300, 6000);
    send(100, 200, 0, 10, 5, 5, 710, 715);
    chk("t4_rdy_lo", cfg_ready, 0);
    wait_kat("t4_w710", 710, 8500);
    repeat (2) @(negedge clk);
    chk("t4_old_s", zs, 1);
    chk("t4_old_k", is, 0);
    chk("t4_old_j", wt, 0);
    wait_kat("t4_w719", 719, 400);
    repeat (2) @(negedge clk);
    chk("t4_rdy_719", cfg_ready, 0);
    n = 0;
    while (!cycle_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t2_cs_seen", cycle_start, 1);
    chk("t2_wrap_kat", kat, 0);
    chk("t4_rdy_at0", cfg_ready, 0);
    @(negedge clk);
    chk("t2_cs_pulse", cycle_start, 0);
    chk("t4_rdy_next", cfg_ready, 1);
    chk("t4_new_s", zs, 0);
    chk("t4_new_w", zw, 1);
    chk("t4_new_j", wt, 0);

    // 6: tdc_sync on a degree tick
    wait_kat("t6_w400", 400, 8500);
    send(0, 50, 0, 0, 0, 0, 0, 0);
    chk("t6_rdy_lo", cfg_ready, 0);
    wait_kat("t6_w412", 412, 300);
    repeat (19) @(negedge clk);
    chk("t6_pre_kat", kat, 412);
    tdc_sync = 1'b1;
    @(negedge clk);
    tdc_sync = 1'b0;
    chk("t6_kat0", kat, 0);
    chk("t6_cs", cycle_start, 1);
    chk("t6_rdy_at0", cfg_ready, 0);
    @(negedge clk);
    chk("t6_rdy_next", cfg_ready, 1);
    chk("t6_cs_pulse", cycle_start, 0);
    chk("t6_new_s", zs, 1);
    chk("t6_new_w", zw, 0);

    // 5: out-of-range table rejected
    send(0, 0, 0, 0, 0, 0, 720, 0);
    chk("t5_err", cfg_err, 1);
    chk("t5_rdy", cfg_ready, 1);
    repeat (3) @(negedge clk);
    chk("t5_rdy_hold", cfg_ready, 1);
    chk("t5_ignored", zs, 1);

    // 7: stop mid-window, then resume
    rpm = 7'd45;
    wait_kat("t7_w30", 30, 900);
    repeat (2) @(negedge clk);
    chk("t7_s_on", zs, 1);
    rpm = 7'd0;
    repeat (5) @(negedge clk);
    chk("t7_s_off", zs, 0);
    frozen = int'(kat);
    chk("t7_kat_stop", frozen, 30);
    repeat (100) @(negedge clk);
    chk("t7_frozen", kat, frozen);
    chk("t7_err_sticky", cfg_err, 1);
    rpm = 7'd45;
    wait_kat("t7_resume", 31, 60);
    repeat (2) @(negedge clk);
    chk("t7_s_resume", zs, 1);

    // reset mid-operation with a pending table
    send(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pend", cfg_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_kat", kat, 0);
    chk("rst_rdy", cfg_ready, 1);
    chk("rst_err", cfg_err, 0);
    chk("rst_drv", {zs, zw, wt, is}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tbl_s", zs, 0);
    chk("rst_rdy2", cfg_ready, 1);

    $display("[TB] %0d tests run, %0d failed",
      n_run, n_fail);
    $finish;
  end

endmodule
